// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: valid/ready command in, valid/ready response out.
// Every APB and response output is registered; cmd_ready is a pure state decode.
module apb_master_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        psel_d, penable_d, pwrite_d;
    logic [31:0] paddr_d, pwdata_d;
    logic        rsp_valid_d, rsp_err_d, rsp_timeout_d;
    logic [31:0] rsp_rdata_d;
    logic        expire;

    assign cmd_ready = (state_q == IDLE);

    // Expiry looks at the count before this edge's increment.
    assign expire = TO_EN && ((cnt_q + CNT_ONE) == TO_LIM);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            psel        <= psel_d;
            penable     <= penable_d;
            pwrite      <= pwrite_d;
            paddr       <= paddr_d;
            pwdata      <= pwdata_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        psel_d        = psel;
        penable_d     = penable;
        pwrite_d      = pwrite;
        paddr_d       = paddr;
        pwdata_d      = pwdata;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    pwrite_d  = cmd_write;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A ready slave wins over an expiring counter.
                if (pready) begin
                    rsp_rdata_d   = pwrite ? 32'h0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (expire) begin
                        rsp_rdata_d   = 32'h0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                        rsp_valid_d   = 1'b1;
                        psel_d        = 1'b0;
                        penable_d     = 1'b0;
                        state_d       = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Testbench for apb_master_bridge: scenario tasks driving a scripted APB slave,
// checked against a transaction-level model of latency, data and error status.
module tb_apb_master_bridge;

    localparam int TMO = 16;

    logic        clk;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int checks;
    int errors;

    logic        nxt_wr;
    logic [31:0] nxt_addr;
    logic [31:0] nxt_wdata;

    apb_master_bridge #(
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .paddr      (paddr),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transfer: starts and ends at a negedge with the bridge idle.
    task automatic do_xfer(input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits,
                           input logic [31:0] rd, input logic serr,
                           input int hold, input logic queue);
        int          acc;
        int          lat;
        int          exp_acc;
        logic        exp_err;
        logic        exp_to;
        logic [31:0] exp_rd;
        bit          done;
        if (waits < TMO) begin
            exp_acc = waits + 1;
            exp_to  = 1'b0;
            exp_err = serr;
            exp_rd  = wr ? 32'h0 : rd;
        end else begin
            exp_acc = TMO;
            exp_to  = 1'b1;
            exp_err = 1'b1;
            exp_rd  = 32'h0;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: got %b expected 1", cmd_ready);
        end
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata} !== {2'b10, wr, addr, wdata}) begin
            errors++;
            $display("FAIL setup: got sel=%b en=%b wr=%b a=%h d=%h expected sel=1 en=0 wr=%b a=%h d=%h",
                     psel, penable, pwrite, paddr, pwdata, wr, addr, wdata);
        end
        pready  = 1'($urandom_range(0, 1));
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
        acc  = 0;
        lat  = 1;
        done = 1'b0;
        while (!done && lat < TMO + 20) begin
            @(negedge clk);
            lat++;
            if (rsp_valid === 1'b1) begin
                done = 1'b1;
            end else begin
                checks++;
                if ({psel, penable, pwrite, paddr, pwdata} !== {2'b11, wr, addr, wdata}) begin
                    errors++;
                    $display("FAIL access: got sel=%b en=%b a=%h expected sel=1 en=1 a=%h",
                             psel, penable, paddr, addr);
                end
                acc++;
                pready  = (acc == waits + 1);
                pslverr = (acc == waits + 1) ? serr : 1'($urandom_range(0, 1));
                prdata  = (acc == waits + 1) ? rd : $urandom;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL rsp_wait: got no rsp_valid after %0d cycles expected %0d", lat, exp_acc + 2);
        end
        pready  = 1'($urandom_range(0, 1));
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
        checks++;
        if (lat != exp_acc + 2 || acc != exp_acc) begin
            errors++;
            $display("FAIL latency: got lat=%0d enable=%0d expected lat=%0d enable=%0d",
                     lat, acc, exp_acc + 2, exp_acc);
        end
        checks++;
        if ({rsp_rdata, rsp_err, rsp_timeout} !== {exp_rd, exp_err, exp_to}) begin
            errors++;
            $display("FAIL rsp: got rd=%h err=%b to=%b expected rd=%h err=%b to=%b",
                     rsp_rdata, rsp_err, rsp_timeout, exp_rd, exp_err, exp_to);
        end
        checks++;
        if ({psel, penable, cmd_ready} !== 3'b000) begin
            errors++;
            $display("FAIL resp_state: got sel=%b en=%b rdy=%b expected 000", psel, penable, cmd_ready);
        end
        for (int i = 0; i < hold; i++) begin
            if (queue) begin
                cmd_valid = 1'b1;
                cmd_write = nxt_wr;
                cmd_addr  = nxt_addr;
                cmd_wdata = nxt_wdata;
            end
            rsp_ready = 1'b0;
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready, psel, penable}
                !== {1'b1, exp_rd, exp_err, exp_to, 3'b000}) begin
                errors++;
                $display("FAIL hold: got v=%b rd=%h err=%b to=%b rdy=%b sel=%b expected v=1 rd=%h err=%b to=%b rdy=0 sel=0",
                         rsp_valid, rsp_rdata, rsp_err, rsp_timeout, cmd_ready, psel, exp_rd, exp_err, exp_to);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        pready    = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready, psel, penable} !== 4'b0100) begin
            errors++;
            $display("FAIL release: got v=%b rdy=%b sel=%b en=%b expected 0100",
                     rsp_valid, cmd_ready, psel, penable);
        end
    endtask

    task automatic test_reset;
        rstn      = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        #1 rstn = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout}
            !== {1'b1, 3'b000, 64'h0, 1'b0, 32'h0, 2'b00}) begin
            errors++;
            $display("FAIL reset: got rdy=%b sel=%b en=%b a=%h v=%b rd=%h expected rdy=1 all else 0",
                     cmd_ready, psel, penable, paddr, rsp_valid, rsp_rdata);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_zero_wait;
        do_xfer(1'b1, 32'h08, 32'hA5A55A5A, 0, $urandom, 1'b0, 0, 1'b0);
    endtask

    task automatic test_read_wait;
        do_xfer(1'b0, 32'h0C, $urandom, 2, 32'h12345678, 1'b0, 0, 1'b0);
    endtask

    task automatic test_slverr;
        do_xfer(1'b1, 32'h10, $urandom, 0, $urandom, 1'b1, 0, 1'b0);
        do_xfer(1'b0, 32'h14, $urandom, 0, 32'h0BADF00D, 1'b0, 0, 1'b0);
    endtask

    task automatic test_timeout;
        do_xfer(1'b0, 32'h18, $urandom, 100, 32'hDEADBEEF, 1'b0, 0, 1'b0);
        do_xfer(1'b0, 32'h1C, $urandom, TMO - 1, 32'h55AA33CC, 1'b0, 0, 1'b0);
        do_xfer(1'b1, 32'h20, $urandom, TMO - 2, $urandom, 1'b1, 0, 1'b0);
    endtask

    task automatic test_back_to_back;
        nxt_wr    = 1'b0;
        nxt_addr  = 32'h0000_0030;
        nxt_wdata = $urandom;
        do_xfer(1'b1, 32'h2C, $urandom, 0, $urandom, 1'b0, 5, 1'b1);
        do_xfer(nxt_wr, nxt_addr, nxt_wdata, 1, 32'hFEEDC0DE, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset_mid;
        cmd_write = 1'b0;
        cmd_addr  = 32'h40;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        pready    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({psel, penable} !== 2'b11) begin
            errors++;
            $display("FAIL mid_access: got sel=%b en=%b expected 11", psel, penable);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({psel, penable, rsp_valid, cmd_ready, paddr} !== {4'b0001, 32'h0}) begin
            errors++;
            $display("FAIL async_reset: got sel=%b en=%b v=%b rdy=%b a=%h expected 0001 a=0",
                     psel, penable, rsp_valid, cmd_ready, paddr);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL post_reset: got rdy=%b sel=%b v=%b expected 100", cmd_ready, psel, rsp_valid);
        end
        do_xfer(1'b0, 32'h04, $urandom, 1, 32'hCAFE0004, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random;
        int w;
        for (int n = 0; n < 24; n++) begin
            w = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TMO - 2, TMO + 2))
                                            : int'($urandom_range(0, 3));
            do_xfer(1'($urandom_range(0, 1)), $urandom, $urandom, w, $urandom,
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
